// File: rtl/nn_cfg_pkg.sv
// rtl/nn_cfg_pkg.sv - shared types and constants for the nn configuration loader
package nn_cfg_pkg;

    localparam int CFG_WORDS      = 4;
    localparam int BYTES_PER_DESC = 8;

    localparam logic [1:0] CFG_IDX_MODE  = 2'd0;
    localparam logic [1:0] CFG_IDX_MOVE  = 2'd1;
    localparam logic [1:0] CFG_IDX_BASE  = 2'd2;
    localparam logic [1:0] CFG_IDX_WRCNT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_CFG_WR,
        ST_START,
        ST_WAIT_FIN
`ifdef NN_CFG_TIMEOUT_EN
        , ST_ERR
`endif
    } state_t;

endpackage

// File: rtl/nn_cfg_wdog.sv
// rtl/nn_cfg_wdog.sv - stall watchdog counter, used when NN_CFG_TIMEOUT_EN is defined
module nn_cfg_wdog #(
    parameter int TO_W = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_expired
);

    logic [TO_W-1:0] cnt_q;

    // Counting only happens in wait states, so dropping i_en restarts on the next entry.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q <= '0;
        end else if (!i_en) begin
            cnt_q <= '0;
        end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + TO_W'(1);
        end
    end

    assign o_expired = i_en && (cnt_q == '1);

endmodule

// File: rtl/nn_cfg_loader.sv
// rtl/nn_cfg_loader.sv - DMA-fed per-layer config master for nn; NN_CFG_TIMEOUT_EN adds a stall watchdog
module nn_cfg_loader
    import nn_cfg_pkg::*;
#(
    parameter int DMA_AW  = 10,
    parameter int DMA_DW  = 8,
    parameter int CFG_W   = 16,
    parameter int LAYER_W = 8,
    parameter int TO_W    = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_go,
    input  logic [DMA_AW-1:0]  i_desc_base_addr,
    input  logic [LAYER_W-1:0] i_layer_count,
    output logic               o_dma_rd_en,
    output logic [DMA_AW-1:0]  o_dma_rd_addr,
    input  logic [DMA_DW-1:0]  i_dma_rd_data,
    input  logic               i_dma_rd_valid,
    output logic [CFG_W-1:0]   o_cfg,
    output logic [1:0]         o_cfg_addr,
    output logic               o_cfg_wr_en,
    output logic               o_nn_start,
    input  logic               i_nn_finish,
    output logic               o_busy,
    output logic               o_done,
    output logic [LAYER_W-1:0] o_layer_idx,
    output logic               o_error
);

    localparam int BYTE_W = $clog2(BYTES_PER_DESC);

    state_t              state_q, state_d;
    logic [DMA_AW-1:0]   base_q;
    logic [LAYER_W-1:0]  count_q;
    logic [LAYER_W-1:0]  layer_q;
    logic [BYTE_W-1:0]   byte_q;
    logic [DMA_DW-1:0]   lo_q;
    logic [CFG_W-1:0]    cfg_q;
    logic [1:0]          cfg_addr_q;
    logic                fin_q;
    logic                done_q;
    logic                go_ok;
    logic                fin_rise;
    logic                last_layer;
    logic                wdog_exp;
    logic [DMA_AW-1:0]   layer_off;

    // A go landing on the done pulse is treated as part of the finished run.
    assign go_ok      = i_go && !done_q;
    assign fin_rise   = i_nn_finish && !fin_q;
    assign last_layer = (layer_q == count_q - LAYER_W'(1));
    assign layer_off  = DMA_AW'(32'(layer_q) * BYTES_PER_DESC);

`ifdef NN_CFG_TIMEOUT_EN
    nn_cfg_wdog #(
        .TO_W (TO_W)
    ) u_wdog (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_en      ((state_q == ST_RD_WAIT) || (state_q == ST_WAIT_FIN)),
        .o_expired (wdog_exp)
    );
    assign o_error = (state_q == ST_ERR);
`else
    assign wdog_exp = 1'b0;
    assign o_error  = |{TO_W{1'b0}};
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (go_ok && (i_layer_count != '0)) begin
                    state_d = ST_RD_REQ;
                end
            end
            ST_RD_REQ: state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (i_dma_rd_valid) begin
                    state_d = byte_q[0] ? ST_CFG_WR : ST_RD_REQ;
                end
            end
            ST_CFG_WR: state_d = (cfg_addr_q == CFG_IDX_WRCNT) ? ST_START : ST_RD_REQ;
            ST_START:  state_d = ST_WAIT_FIN;
            ST_WAIT_FIN: begin
                if (fin_rise) begin
                    state_d = last_layer ? ST_IDLE : ST_RD_REQ;
                end
            end
`ifdef NN_CFG_TIMEOUT_EN
            ST_ERR: state_d = ST_ERR;
`endif
            default: state_d = ST_IDLE;
        endcase
`ifdef NN_CFG_TIMEOUT_EN
        if (wdog_exp) begin
            state_d = ST_ERR;
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            base_q     <= '0;
            count_q    <= '0;
            layer_q    <= '0;
            byte_q     <= '0;
            lo_q       <= '0;
            cfg_q      <= '0;
            cfg_addr_q <= '0;
            fin_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            fin_q  <= i_nn_finish;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (go_ok) begin
                        base_q  <= i_desc_base_addr;
                        count_q <= i_layer_count;
                        layer_q <= '0;
                        byte_q  <= '0;
                        done_q  <= (i_layer_count == '0);
                    end
                end
                ST_RD_WAIT: begin
                    if (i_dma_rd_valid && !wdog_exp) begin
                        byte_q <= byte_q + BYTE_W'(1);
                        if (!byte_q[0]) begin
                            lo_q <= i_dma_rd_data;
                        end else begin
                            cfg_q      <= CFG_W'({i_dma_rd_data, lo_q});
                            cfg_addr_q <= byte_q[BYTE_W-1:1];
                        end
                    end
                end
                ST_WAIT_FIN: begin
                    if (fin_rise && !wdog_exp) begin
                        if (last_layer) begin
                            done_q <= 1'b1;
                        end else begin
                            layer_q <= layer_q + LAYER_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_dma_rd_en   = (state_q == ST_RD_REQ);
    assign o_dma_rd_addr = base_q + layer_off + DMA_AW'(byte_q);
    assign o_cfg         = cfg_q;
    assign o_cfg_addr    = cfg_addr_q;
    assign o_cfg_wr_en   = (state_q == ST_CFG_WR);
    assign o_nn_start    = (state_q == ST_START);
    assign o_busy        = (state_q != ST_IDLE)
`ifdef NN_CFG_TIMEOUT_EN
                           && (state_q != ST_ERR)
`endif
                           ;
    assign o_done        = done_q;
    assign o_layer_idx   = layer_q;

endmodule

// File: tb/tb_nn_cfg_loader.sv
// tb/tb_nn_cfg_loader.sv - self-checking bench for nn_cfg_loader
module tb_nn_cfg_loader;

    typedef struct {
        logic [9:0] base;
        logic [7:0] count;
        int         lat;
        int         exp_gap;
    } vec_t;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_go;
    logic [9:0]  i_desc_base_addr;
    logic [7:0]  i_layer_count;
    logic        o_dma_rd_en;
    logic [9:0]  o_dma_rd_addr;
    logic [7:0]  i_dma_rd_data;
    logic        i_dma_rd_valid;
    logic [15:0] o_cfg;
    logic [1:0]  o_cfg_addr;
    logic        o_cfg_wr_en;
    logic        o_nn_start;
    logic        i_nn_finish;
    logic        o_busy;
    logic        o_done;
    logic [7:0]  o_layer_idx;
    logic        o_error;
    logic        fin_auto;
    logic        fin_man;

    assign i_nn_finish = fin_auto | fin_man;

    always #5 i_clk = ~i_clk;

    nn_cfg_loader dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_go             (i_go),
        .i_desc_base_addr (i_desc_base_addr),
        .i_layer_count    (i_layer_count),
        .o_dma_rd_en      (o_dma_rd_en),
        .o_dma_rd_addr    (o_dma_rd_addr),
        .i_dma_rd_data    (i_dma_rd_data),
        .i_dma_rd_valid   (i_dma_rd_valid),
        .o_cfg            (o_cfg),
        .o_cfg_addr       (o_cfg_addr),
        .o_cfg_wr_en      (o_cfg_wr_en),
        .o_nn_start       (o_nn_start),
        .i_nn_finish      (i_nn_finish),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_layer_idx      (o_layer_idx),
        .o_error          (o_error)
    );

    logic [7:0]  mem [0:1023];
    logic [9:0]  rd_exp [$];
    logic [17:0] cfg_exp [$];
    logic [7:0]  lay_exp [$];
    logic [15:0] cfg_log [$];
    logic [15:0] spec_words [4];
    vec_t        vecs [4];

    int n_checks = 0;
    int n_err    = 0;
    int cyc = 0, lat = 1, dram_cnt = 0, fin_cnt = 0;
    int rd_cnt = 0, starts = 0, dones = 0, first_rd = -1, start_cyc = -1;
    int snap;
    logic [9:0] dram_addr;
    logic prev_rd = 1'b0, prev_done = 1'b0, auto_fin = 1'b1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // One clock: drive DRAM/finish responses after the edge, observe outputs on the falling edge.
    task automatic tick();
        logic [17:0] ecfg;
        logic [9:0]  eaddr;
        logic [7:0]  elay;
        @(posedge i_clk);
        #1;
        i_go           = 1'b0;
        i_dma_rd_valid = 1'b0;
        fin_auto       = 1'b0;
        if (dram_cnt > 0) begin
            dram_cnt--;
            if (dram_cnt == 0) begin
                i_dma_rd_valid = 1'b1;
                i_dma_rd_data  = mem[dram_addr];
            end
        end
        if (fin_cnt > 0) begin
            fin_cnt--;
            if (fin_cnt == 0) fin_auto = 1'b1;
        end
        @(negedge i_clk);
        cyc++;
        if (o_dma_rd_en) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
            check("rd_en_single", 32'(prev_rd), 32'd0);
            check("rd_outstanding", 32'(dram_cnt), 32'd0);
            eaddr = (rd_exp.size() > 0) ? rd_exp.pop_front() : 'x;
            check("rd_addr", 32'(o_dma_rd_addr), 32'(eaddr));
            dram_cnt  = lat;
            dram_addr = o_dma_rd_addr;
        end
        if (o_cfg_wr_en) begin
            ecfg = (cfg_exp.size() > 0) ? cfg_exp.pop_front() : 'x;
            check("cfg_write", 32'({o_cfg_addr, o_cfg}), 32'(ecfg));
            cfg_log.push_back(o_cfg);
        end
        if (o_nn_start) begin
            starts++;
            if (start_cyc < 0) start_cyc = cyc;
            elay = (lay_exp.size() > 0) ? lay_exp.pop_front() : 'x;
            check("start_layer", 32'(o_layer_idx), 32'(elay));
            if (auto_fin) fin_cnt = 3;
        end
        if (o_done) begin
            dones++;
            check("done_busy_low", 32'(o_busy), 32'd0);
            check("done_single", 32'(prev_done), 32'd0);
        end
        prev_rd   = o_dma_rd_en;
        prev_done = o_done;
    endtask

    task automatic clear_sb();
        rd_exp.delete();
        cfg_exp.delete();
        lay_exp.delete();
        cfg_log.delete();
        rd_cnt = 0; starts = 0; dones = 0; first_rd = -1; start_cyc = -1;
        dram_cnt = 0; fin_cnt = 0;
    endtask

    task automatic push_expect(input logic [9:0] base, input logic [7:0] count);
        logic [9:0] a0;
        logic [9:0] a1;
        for (int l = 0; l < int'(count); l++) begin
            lay_exp.push_back(8'(l));
            for (int b = 0; b < 8; b++) rd_exp.push_back(base + 10'(8 * l + b));
            for (int w = 0; w < 4; w++) begin
                a0 = base + 10'(8 * l + 2 * w);
                a1 = a0 + 10'd1;
                cfg_exp.push_back({2'(w), mem[a1], mem[a0]});
            end
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        int d0 = dones;
        while (dones == d0 && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(dones != d0), 32'd1);
    endtask

    task automatic wait_start(input string name, input int budget);
        int n = 0;
        int s0 = starts;
        while (starts == s0 && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(starts != s0), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        i_rst = 1'b0; i_go = 1'b0; i_desc_base_addr = '0; i_layer_count = '0;
        i_dma_rd_data = '0; i_dma_rd_valid = 1'b0; fin_auto = 1'b0; fin_man = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[10'h040] = 8'h00; mem[10'h041] = 8'hCE; mem[10'h042] = 8'h04; mem[10'h043] = 8'h04;
        mem[10'h044] = 8'h03; mem[10'h045] = 8'h00; mem[10'h046] = 8'hC8; mem[10'h047] = 8'h00;
        spec_words[0] = 16'hCE00; spec_words[1] = 16'h0404;
        spec_words[2] = 16'h0003; spec_words[3] = 16'h00C8;
        vecs[0] = '{10'h040, 8'd1, 1, 20};
        vecs[1] = '{10'h3FC, 8'd2, 1, 20};
        vecs[2] = '{10'h100, 8'd3, 5, 52};
        vecs[3] = '{10'h3FA, 8'd1, 2, 28};

        repeat (3) tick();
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_strobes", 32'({o_dma_rd_en, o_cfg_wr_en, o_nn_start, o_error}), 32'd0);
        check("rst_data", 32'({o_dma_rd_addr, o_cfg_addr, o_layer_idx}), 32'd0);
        check("rst_cfg", 32'(o_cfg), 32'd0);
        i_rst = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 4; i++) begin
            clear_sb();
            lat = vecs[i].lat;
            auto_fin = 1'b1;
            push_expect(vecs[i].base, vecs[i].count);
            i_desc_base_addr = vecs[i].base;
            i_layer_count    = vecs[i].count;
            i_go             = 1'b1;
            wait_done($sformatf("c%0d_done_seen", i), 3000);
            repeat (3) tick();
            check($sformatf("c%0d_done_count", i), 32'(dones), 32'd1);
            check($sformatf("c%0d_starts", i), 32'(starts), 32'(vecs[i].count));
            check($sformatf("c%0d_reads", i), 32'(rd_cnt), 32'(8 * int'(vecs[i].count)));
            check($sformatf("c%0d_cfg_left", i), 32'(cfg_exp.size()), 32'd0);
            check($sformatf("c%0d_start_gap", i), 32'(start_cyc - first_rd), 32'(vecs[i].exp_gap));
            check($sformatf("c%0d_busy_after", i), 32'(o_busy), 32'd0);
            if (i == 0) begin
                for (int k = 0; k < 4; k++) begin
                    check($sformatf("spec_word%0d", k), 32'(cfg_log[k]), 32'(spec_words[k]));
                end
            end
        end

        // finish already high before start, plus go pulses mid-load
        clear_sb();
        lat = 1;
        auto_fin = 1'b0;
        fin_man = 1'b1;
        push_expect(10'h040, 8'd1);
        i_desc_base_addr = 10'h040;
        i_layer_count    = 8'd1;
        i_go             = 1'b1;
        tick();
        repeat (3) begin
            repeat (3) tick();
            i_desc_base_addr = 10'h200;
            i_layer_count    = 8'd5;
            i_go             = 1'b1;
        end
        wait_start("lvl_start_seen", 100);
        repeat (3) tick();
        check("lvl_held_busy", 32'(o_busy), 32'd1);
        check("lvl_held_nodone", 32'(dones), 32'd0);
        fin_man = 1'b0;
        repeat (2) tick();
        check("lvl_low_busy", 32'(o_busy), 32'd1);
        fin_man = 1'b1;
        wait_done("lvl_rise_done", 10);
        fin_man = 1'b0;
        tick();
        check("lvl_reads", 32'(rd_cnt), 32'd8);
        check("lvl_starts", 32'(starts), 32'd1);

        // reset while waiting for finish
        clear_sb();
        push_expect(10'h100, 8'd2);
        i_desc_base_addr = 10'h100;
        i_layer_count    = 8'd2;
        i_go             = 1'b1;
        wait_start("rst_start_seen", 100);
        repeat (2) tick();
        i_rst = 1'b0;
        #1;
        check("midrst_busy", 32'(o_busy), 32'd0);
        check("midrst_strobes", 32'({o_dma_rd_en, o_cfg_wr_en, o_nn_start, o_done, o_error}), 32'd0);
        check("midrst_data", 32'({o_dma_rd_addr, o_cfg_addr, o_layer_idx}), 32'd0);
        check("midrst_cfg", 32'(o_cfg), 32'd0);
        snap = rd_cnt;
        repeat (3) tick();
        i_rst = 1'b1;
        clear_sb();
        repeat (5) tick();
        check("postrst_reads", 32'(rd_cnt + snap), 32'(snap));
        check("postrst_idle", 32'({o_busy, o_done}), 32'd0);

        // zero layers, then a go landing on the done pulse
        clear_sb();
        auto_fin = 1'b1;
        i_desc_base_addr = 10'h123;
        i_layer_count    = 8'd0;
        i_go             = 1'b1;
        tick();
        check("cnt0_done", 32'(o_done), 32'd1);
        check("cnt0_busy", 32'(o_busy), 32'd0);
        i_layer_count = 8'd1;
        i_go          = 1'b1;
        repeat (6) tick();
        check("cnt0_done_count", 32'(dones), 32'd1);
        check("cnt0_activity", 32'(rd_cnt + cfg_log.size() + starts), 32'd0);
        check("cnt0_go_on_done", 32'(o_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/nn_cfg_loader.md
Name: nn_cfg_loader

Overview:
Autonomous configuration master for the nn core. It fetches per-layer 4-word configuration descriptors from DRAM over the byte-wide DMA read interface and packs byte pairs into 16-bit words. It drives them onto nn's i_cfg/i_cfg_addr/i_cfg_wr_en configuration port, pulses nn's i_start, and waits for nn's o_finish before loading the next layer. It replaces testbench-driven configuration writes and sits between the DRAM model and nn.

Parameters:
DMA_AW, 10, DMA byte-address width
DMA_DW, 8, DMA data width (fixed 8; two bytes per config word)
CFG_W, 16, config word width
LAYER_W, 8, width of layer count/index
TO_W, 16, watchdog counter width (used only with macro)

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-low reset
i_go  in  1  pulse: begin loading; ignored while o_busy
i_desc_base_addr  in  DMA_AW  byte address of layer 0 descriptor
i_layer_count  in  LAYER_W  number of layers to run
o_dma_rd_en  out  1  one-cycle read request
o_dma_rd_addr  out  DMA_AW  read byte address
i_dma_rd_data  in  DMA_DW  read data
i_dma_rd_valid  in  1  read data valid
o_cfg  out  CFG_W  config word to nn
o_cfg_addr  out  2  config register index 0..3
o_cfg_wr_en  out  1  config write strobe
o_nn_start  out  1  one-cycle start pulse to nn
i_nn_finish  in  1  nn finish (level or pulse)
o_busy  out  1  high from go acceptance until done
o_done  out  1  one-cycle pulse after last layer finishes
o_layer_idx  out  LAYER_W  layer currently being processed
o_error  out  1  sticky watchdog error (0 when macro absent)

Behaviour:
- Reset: all outputs 0; state IDLE; layer index, byte/word counters, finish edge register cleared. Reset mid-operation aborts immediately with no further DMA or cfg activity.
- Descriptor layout: 8 bytes per layer at base + 8*layer; word k in bytes 2k (low) and 2k+1 (high), little-endian. Addresses wrap modulo 2^DMA_AW.
- States: IDLE, RD_REQ, RD_WAIT, CFG_WR, START, WAIT_FIN, (ERR with macro).
- IDLE: on i_go, latch base and count, set busy; count==0 -> o_done pulses next cycle, return to IDLE, no reads; else RD_REQ.
- RD_REQ: o_dma_rd_en=1 for exactly one cycle with address; -> RD_WAIT.
- RD_WAIT: hold until i_dma_rd_valid; capture byte; low byte -> RD_REQ for next address; high byte -> CFG_WR. Valid outside RD_WAIT ignored. One outstanding read at most.
- CFG_WR: o_cfg={hi,lo}, o_cfg_addr=word index, o_cfg_wr_en=1 for one cycle; o_cfg/o_cfg_addr hold until next write. Word 3 -> START; else RD_REQ.
- START: o_nn_start=1 one cycle -> WAIT_FIN.
- WAIT_FIN: advance only on rising edge of i_nn_finish (registered previous value); a level already high on entry does not count. Then last layer -> o_done pulse, busy drops same cycle, IDLE; else layer_idx+1 -> RD_REQ.
- With 1-cycle DRAM latency: 5 cycles per word; o_nn_start exactly 20 cycles after the first o_dma_rd_en cycle.
- i_go while busy ignored; i_go coincident with o_done ignored.

Optional Feature:
NN_CFG_TIMEOUT_EN: watchdog counts cycles in RD_WAIT or WAIT_FIN, clearing on each state entry. Reaching 2^TO_W-1 -> ERR: o_error=1 (sticky), busy=0, no o_done; only reset exits. Without the macro there is no counter, no ERR state, and o_error is tied 0.

Decomposition:
- Package nn_cfg_pkg: state enum, CFG_WORDS=4, BYTES_PER_DESC=8, cfg register index constants (MODE=0, MOVE=1, BASE=2, WRCNT=3).
- Sub-module nn_cfg_wdog (counter + compare), instantiated only under NN_CFG_TIMEOUT_EN; remaining logic stays in one module.

Test Plan:
- Single layer: DRAM 0x040..0x047 = 00 CE 04 04 03 00 C8 00, base 0x040, count 1 -> cfg writes (0,0xCE00),(1,0x0404),(2,0x0003),(3,0x00C8) in order; start 20 cycles after first rd_en; finish pulse -> o_done 1 cycle, busy 0.
- Two layers at base 0x3FC: reads 0x3FC..0x3FF, 0x000..0x00B (wrap); o_layer_idx 0 then 1; two start pulses; one o_done.
- Count 0 -> o_done the cycle after go, zero rd_en/cfg_wr_en/start activity.
- i_nn_finish held high before start, dropped, re-asserted -> advance only on re-assertion; i_go pulses mid-load -> no effect.
- DRAM valid delayed 5 cycles -> rd_en remains single-cycle, no re-issue, correct bytes; reset asserted in WAIT_FIN -> all outputs 0, IDLE.
- With NN_CFG_TIMEOUT_EN, TO_W=4, finish never asserted -> o_error=1 after 15 cycles in WAIT_FIN, busy 0, no o_done.
